// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcode constants reused by the processor and the
// program loader, plus the loader's state encoding.
package mips32_pkg;

   localparam logic [5:0] ADD  = 6'h00;
   localparam logic [5:0] OR   = 6'h03;
   localparam logic [5:0] ADDI = 6'h0a;
   localparam logic [5:0] HLT  = 6'h3f;

   typedef enum logic [2:0] {
      LOAD,
      START,
      RUN,
      DONE,
      ERROR
   } loader_state_t;

   function automatic logic [5:0] opcode(input logic [31:0] instr);
      return instr[31:26];
   endfunction

endpackage

// File: rtl/mips32_prog_loader.sv
// Streams a program image into MIPS32 memory, starts the core at PC 0 and
// reports completion once the core halts.
//
// state | meaning
// LOAD  | accepting image words; core held
// START | one-cycle cpu_start pulse, hold released
// RUN   | core executing; halt watched after the first cycle
// DONE  | core halted; a new beat begins the next image
// ERROR | overflow or missing HLT; held until reset
module mips32_prog_loader
   import mips32_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter int          MAX_WORDS = 1024,
   parameter logic [5:0]  HLT_OPC   = HLT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [31:0]       s_data,
   input  logic              s_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              cpu_start,
   input  logic              cpu_halted,
   output logic [ADDR_W:0]   load_count,
   output logic              done,
   output logic              err_overflow,
   output logic              err_no_hlt
);

   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

   loader_state_t   state;
   logic            start_pend;
   logic            run_first;
   logic            accept;
   logic            beat_ovf;
   logic [ADDR_W:0] next_count;

   // The write issued last cycle has not yet been counted; include it so
   // back-to-back beats see the true fill level.
   assign next_count = load_count + {{ADDR_W{1'b0}}, mem_we};
   assign accept     = s_valid & s_ready;
   assign beat_ovf   = (state == LOAD) && (next_count == MAX_CNT);
   assign mem_addr   = load_count[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= LOAD;
         start_pend   <= 1'b0;
         run_first    <= 1'b0;
         s_ready      <= 1'b0;
         cpu_hold     <= 1'b1;
         cpu_start    <= 1'b0;
         mem_we       <= 1'b0;
         mem_wdata    <= '0;
         load_count   <= '0;
         done         <= 1'b0;
         err_overflow <= 1'b0;
         err_no_hlt   <= 1'b0;
      end else begin
         mem_we     <= 1'b0;
         cpu_start  <= 1'b0;
         load_count <= next_count;

         unique case (state)
            LOAD: begin
               if (start_pend) begin
                  start_pend <= 1'b0;
                  state      <= START;
                  cpu_start  <= 1'b1;
                  cpu_hold   <= 1'b0;
               end else if (!accept) begin
                  s_ready <= 1'b1;
               end
            end
            START: begin
               state     <= RUN;
               run_first <= 1'b1;
            end
            RUN: begin
               // HALTED may still be set from the previous program here
               if (run_first) begin
                  run_first <= 1'b0;
               end else if (cpu_halted) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b1;
                  s_ready  <= 1'b1;
               end
            end
            DONE: begin
            end
            ERROR: begin
               s_ready  <= 1'b0;
               cpu_hold <= 1'b1;
            end
            default: state <= ERROR;
         endcase

         // Beats only arrive in LOAD or DONE, the only states with s_ready set.
         if (accept) begin
            if (beat_ovf) begin
               err_overflow <= 1'b1;
               s_ready      <= 1'b0;
               state        <= ERROR;
            end else begin
               mem_we    <= 1'b1;
               mem_wdata <= s_data;
               if (state == DONE) begin
                  done       <= 1'b0;
                  load_count <= '0;
                  state      <= LOAD;
               end
               if (s_last) begin
                  s_ready <= 1'b0;
                  if (opcode(s_data) != HLT_OPC) begin
                     err_no_hlt <= 1'b1;
                     state      <= ERROR;
                  end else begin
                     start_pend <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: write scoreboard, start timing,
// halt detection, reload, reset abort, missing HLT and overflow.
module tb_mips32_prog_loader;
   import mips32_pkg::*;

   localparam int AW  = 10;
   localparam int AW4 = 2;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, rst4_n, s_valid, s_last, cpu_halted;
   logic [31:0]   s_data;

   logic          s_ready, mem_we, cpu_hold, cpu_start, done, err_overflow, err_no_hlt;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [AW:0]   load_count;

   logic           s_ready4, mem_we4, cpu_hold4, cpu_start4, done4, err_overflow4, err_no_hlt4;
   logic [AW4-1:0] mem_addr4;
   logic [31:0]    mem_wdata4;
   logic [AW4:0]   load_count4;

   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  start_cnt = 0, start_edge = 0, start_cnt4 = 0;
   int  acc_edge = 0;
   int  exp_addr = 0, exp_addr4 = 0;
   wr_t wq[$];
   wr_t wq4[$];

   logic [31:0] prog [9];
   logic [31:0] img3 [3];

   mips32_prog_loader #(.ADDR_W(AW), .MAX_WORDS(1024), .HLT_OPC(HLT)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .cpu_start(cpu_start),
      .cpu_halted(cpu_halted), .load_count(load_count), .done(done),
      .err_overflow(err_overflow), .err_no_hlt(err_no_hlt)
   );

   mips32_prog_loader #(.ADDR_W(AW4), .MAX_WORDS(4), .HLT_OPC(HLT)) dut4 (
      .clk(clk), .rst_n(rst4_n), .s_valid(s_valid), .s_ready(s_ready4),
      .s_data(s_data), .s_last(s_last), .mem_we(mem_we4), .mem_addr(mem_addr4),
      .mem_wdata(mem_wdata4), .cpu_hold(cpu_hold4), .cpu_start(cpu_start4),
      .cpu_halted(cpu_halted), .load_count(load_count4), .done(done4),
      .err_overflow(err_overflow4), .err_no_hlt(err_no_hlt4)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t w;
      if (mem_we) begin
         chk("unexpected_write", 32'(wq.size() != 0), 32'd1);
         if (wq.size() != 0) begin
            w = wq.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(w.addr));
            chk("wr_data", mem_wdata, w.data);
         end
      end
      if (cpu_start) begin
         start_cnt++;
         start_edge = cyc;
      end
   end

   always @(negedge clk) begin
      wr_t w;
      if (mem_we4) begin
         chk("unexpected_write4", 32'(wq4.size() != 0), 32'd1);
         if (wq4.size() != 0) begin
            w = wq4.pop_front();
            chk("wr_addr4", 32'(mem_addr4), 32'(w.addr));
            chk("wr_data4", mem_wdata4, w.data);
         end
      end
      if (cpu_start4) start_cnt4++;
   end

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offers one beat; the expected write is queued before the accepting edge.
   task automatic send(input logic [31:0] d, input logic l, input bit on4, input bit wr);
      int n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!(on4 ? s_ready4 : s_ready) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("ready_timeout", 32'(n < 50), 32'd1);
      if (wr) begin
         if (on4) begin
            wq4.push_back('{addr: exp_addr4, data: d});
            exp_addr4++;
         end else begin
            wq.push_back('{addr: exp_addr, data: d});
            exp_addr++;
         end
      end
      @(posedge clk);
      #1;
      acc_edge = cyc;
      s_valid  = 1'b0;
      s_last   = 1'b0;
   endtask

   task automatic wait_start(input int prev);
      int n = 0;
      while (start_cnt == prev && n < 50) begin
         idle(1);
         n++;
      end
      chk("start_timeout", 32'(n < 50), 32'd1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 50) begin
         idle(1);
         n++;
      end
      chk("done_timeout", 32'(n < 50), 32'd1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", 32'(s_ready), 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_misc", 32'({mem_we, mem_addr, cpu_start, load_count, done, err_overflow, err_no_hlt}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
               32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
      img3 = '{32'h2801000a, 32'h28020014, 32'hfc000000};
      rst_n = 1'b0; rst4_n = 1'b0;
      s_valid = 1'b0; s_last = 1'b0; s_data = '0; cpu_halted = 1'b0;
      idle(2);
      chk_reset_outputs();
      rst_n = 1'b1;
      idle(1);

      // 9-word program, back to back
      for (int i = 0; i < 9; i++) send(prog[i], i == 8, 1'b0, 1'b1);
      wait_start(0);
      // last beat at edge N, write in the next cycle, pulse the cycle after
      chk("start_latency", 32'(start_edge - acc_edge), 32'd1);
      idle(2);
      chk("start_once", 32'(start_cnt), 32'd1);
      chk("load_count9", 32'(load_count), 32'd9);
      chk("run_hold", 32'(cpu_hold), 32'd0);
      chk("run_ready", 32'(s_ready), 32'd0);
      chk("run_done", 32'(done), 32'd0);
      idle(20);
      cpu_halted = 1'b1;
      wait_done();
      cpu_halted = 1'b0;
      chk("done_hold", 32'(cpu_hold), 32'd1);
      chk("done_ready", 32'(s_ready), 32'd1);
      chk("wq_empty1", 32'(wq.size()), 32'd0);

      // new 3-word image from DONE
      exp_addr = 0;
      send(img3[0], 1'b0, 1'b0, 1'b1);
      chk("done_clear", 32'(done), 32'd0);
      send(img3[1], 1'b0, 1'b0, 1'b1);
      send(img3[2], 1'b1, 1'b0, 1'b1);
      wait_start(1);
      chk("start_latency2", 32'(start_edge - acc_edge), 32'd1);
      idle(2);
      chk("start_twice", 32'(start_cnt), 32'd2);
      chk("load_count3", 32'(load_count), 32'd3);
      idle(5);
      cpu_halted = 1'b1;
      wait_done();
      cpu_halted = 1'b0;

      // same program with random gaps; stale HALTED held into START and first RUN cycle
      exp_addr = 0;
      for (int i = 0; i < 9; i++) begin
         send(prog[i], i == 8, 1'b0, 1'b1);
         if (i != 8) begin
            s_valid = 1'b0;
            idle($urandom_range(0, 3));
         end
      end
      cpu_halted = 1'b1;
      idle(3);
      cpu_halted = 1'b0;
      chk("gap_start_cnt", 32'(start_cnt), 32'd3);
      chk("start_latency3", 32'(start_edge - acc_edge), 32'd1);
      chk("early_done", 32'(done), 32'd0);
      idle(3);
      chk("early_done2", 32'(done), 32'd0);
      chk("load_count9b", 32'(load_count), 32'd9);
      chk("wq_empty2", 32'(wq.size()), 32'd0);
      cpu_halted = 1'b1;
      wait_done();
      cpu_halted = 1'b0;

      // reset after beat 3 aborts; next image restarts at address 0
      exp_addr = 0;
      for (int i = 0; i < 3; i++) send(prog[i], 1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      idle(1);
      chk_reset_outputs();
      rst_n = 1'b1;
      exp_addr = 0;
      send(32'h28030019, 1'b0, 1'b0, 1'b1);
      send(32'h00222000, 1'b0, 1'b0, 1'b1);
      idle(2);
      chk("load_count2", 32'(load_count), 32'd2);
      chk("wq_empty3", 32'(wq.size()), 32'd0);

      // last word is not HLT
      send(32'h00832800, 1'b1, 1'b0, 1'b1);
      idle(3);
      chk("no_hlt_flag", 32'(err_no_hlt), 32'd1);
      chk("no_hlt_ready", 32'(s_ready), 32'd0);
      chk("no_hlt_ovf", 32'(err_overflow), 32'd0);
      idle(5);
      chk("no_hlt_hold", 32'(cpu_hold), 32'd1);
      chk("no_hlt_start", 32'(start_cnt), 32'd3);
      chk("wq_empty4", 32'(wq.size()), 32'd0);

      // overflow on the 4-word instance; fifth beat carries s_last and HLT
      rst_n = 1'b0;
      rst4_n = 1'b1;
      idle(1);
      for (int i = 0; i < 5; i++)
         send((i == 4) ? 32'hfc000000 : 32'h10000000 + 32'(i), i == 4, 1'b1, i < 4);
      idle(3);
      chk("ovf_flag", 32'(err_overflow4), 32'd1);
      chk("ovf_ready", 32'(s_ready4), 32'd0);
      chk("ovf_hold", 32'(cpu_hold4), 32'd1);
      chk("ovf_count", 32'(load_count4), 32'd4);
      chk("ovf_no_hlt", 32'(err_no_hlt4), 32'd0);
      idle(4);
      chk("ovf_start", 32'(start_cnt4), 32'd0);
      chk("wq4_empty", 32'(wq4.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
